// File: rtl/bram_readout_pkg.sv
// -----------------------------------------------------------------------------
// bram_readout_pkg
//   Shared beamformer definitions: default RAM geometry and the readout FSM
//   state encoding. Imported by bram_readout.
// -----------------------------------------------------------------------------
package bram_readout_pkg;

    // Default output-signal RAM geometry (2048 x 12-bit samples).
    localparam int unsigned BF_ADDR_W = 11;
    localparam int unsigned BF_DATA_W = 12;

    // Readout FSM states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWait    = 3'd1,
        StIssue   = 3'd2,
        StCapture = 3'd3,
        StPresent = 3'd4,
        StDone    = 3'd5
    } rd_state_e;

    // Every state except idle counts as busy.
    function automatic logic state_is_busy(input rd_state_e st);
        return (st != StIdle);
    endfunction

endpackage

// File: rtl/bram_readout.sv
// -----------------------------------------------------------------------------
// bram_readout
//   Drains samples from the external output-signal RAM and streams them out
//   over a valid/ready interface. A drain reads num_samples consecutive
//   addresses starting at start_addr (wrapping modulo 2^ADDR_W) and never
//   reads past what the beamformer has written (wr_count).
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   begin a drain (only honoured in idle)
//   start_addr   in   first RAM address of the drain
//   num_samples  in   samples to drain, 0..2^ADDR_W
//   wr_count     in   samples written by the beamformer since start_addr
//   ram_address  out  RAM read address (holds its last value)
//   ram_rden     out  RAM read enable, one cycle per sample
//   ram_q        in   RAM read data, one cycle after ram_rden
//   out_data     out  streamed sample
//   out_valid    out  out_data is valid
//   out_ready    in   downstream accepts the sample
//   busy         out  high whenever not idle
//   done         out  one-cycle pulse at the end of a drain
// -----------------------------------------------------------------------------
module bram_readout
    import bram_readout_pkg::*;
#(
    parameter int unsigned ADDR_W = BF_ADDR_W,
    parameter int unsigned DATA_W = BF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_samples,
    input  logic [ADDR_W:0]   wr_count,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = ADDR_W + 1;

    rd_state_e         r_state;
    rd_state_e         w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [CntW-1:0]   r_rd_cnt;
    logic [CntW-1:0]   w_rd_cnt_next;
    logic [CntW-1:0]   r_target;
    logic [CntW-1:0]   w_target_next;
    logic [ADDR_W-1:0] r_ram_address;
    logic [ADDR_W-1:0] w_ram_address_next;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_next;

    logic [CntW-1:0]   w_rd_cnt_inc;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_last;
    logic              w_next_written;

    // Address increment wraps naturally at the register width.
    assign w_addr_inc     = r_addr + ADDR_W'(1);
    assign w_rd_cnt_inc   = r_rd_cnt + CntW'(1);
    assign w_last         = (w_rd_cnt_inc == r_target);
    // The sample after the one being handed over is already in RAM.
    assign w_next_written = (w_rd_cnt_inc < wr_count);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_rd_cnt      <= '0;
            r_target      <= '0;
            r_ram_address <= '0;
            r_out_data    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_addr        <= w_addr_next;
            r_rd_cnt      <= w_rd_cnt_next;
            r_target      <= w_target_next;
            r_ram_address <= w_ram_address_next;
            r_out_data    <= w_out_data_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_addr_next        = r_addr;
        w_rd_cnt_next      = r_rd_cnt;
        w_target_next      = r_target;
        w_ram_address_next = r_ram_address;
        w_out_data_next    = r_out_data;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_addr_next   = start_addr;
                    w_target_next = num_samples;
                    w_rd_cnt_next = '0;
                    w_state_next  = (num_samples == '0) ? StDone : StWait;
                end
            end

            StWait: begin
                // Only read an address once the beamformer has written it.
                if (r_rd_cnt < wr_count) begin
                    w_ram_address_next = r_addr;
                    w_state_next       = StIssue;
                end
            end

            StIssue: begin
                w_state_next = StCapture;
            end

            StCapture: begin
                // One-cycle RAM latency: ram_q belongs to the read just issued.
                w_out_data_next = ram_q;
                w_state_next    = StPresent;
            end

            StPresent: begin
                if (out_ready) begin
                    w_rd_cnt_next = w_rd_cnt_inc;
                    w_addr_next   = w_addr_inc;
                    if (w_last) begin
                        w_state_next = StDone;
                    end else if (w_next_written) begin
                        // Skip the wait state when data is already available so
                        // a continuously ready sink sees one sample per 3 cycles.
                        w_ram_address_next = w_addr_inc;
                        w_state_next       = StIssue;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end

            StDone: begin
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state so reset clears them immediately.
    // -------------------------------------------------------------------------
    assign ram_address = r_ram_address;
    assign ram_rden    = (r_state == StIssue);
    assign out_data    = r_out_data;
    assign out_valid   = (r_state == StPresent);
    assign busy        = state_is_busy(r_state);
    assign done        = (r_state == StDone);

endmodule

// File: tb/tb_bram_readout.sv
// -----------------------------------------------------------------------------
// tb_bram_readout
//   Directed bench for bram_readout with a one-cycle-latency RAM model whose
//   contents are mem[i] = i + 100.
// -----------------------------------------------------------------------------
module tb_bram_readout;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] start_addr;
    logic [11:0] num_samples;
    logic [11:0] wr_count;
    logic [10:0] ram_address;
    logic        ram_rden;
    logic [11:0] ram_q;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [11:0] mem [0:2047];

    bram_readout #(
        .ADDR_W(11),
        .DATA_W(12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .num_samples(num_samples),
        .wr_count   (wr_count),
        .ram_address(ram_address),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 12'(i + 100);
        ram_q = '0;
    end

    always @(posedge clk) begin
        if (ram_rden) ram_q <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"},  32'(ram_rden),    0);
        chk({tag, "_addr"},  32'(ram_address), 0);
        chk({tag, "_data"},  32'(out_data),    0);
        chk({tag, "_valid"}, 32'(out_valid),   0);
        chk({tag, "_busy"},  32'(busy),        0);
        chk({tag, "_done"},  32'(done),        0);
    endtask

    // Start a drain and follow it to completion, checking every RAM read
    // address, every handed-over sample, hold stability and the done pulse.
    task automatic run_drain(input int s_addr, input int n, input int wr0,
                             input int raise_at, input int wr1, input bit rnd,
                             input bit chk_gap, input int glitch_at);
        int          k;
        int          rd;
        int          last_hs;
        bit          hold;
        bit          got_done;
        logic [11:0] held;
        start_addr  = 11'(s_addr);
        num_samples = 12'(n);
        wr_count    = 12'(wr0);
        out_ready   = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        k        = 0;
        rd       = 0;
        last_hs  = -1;
        hold     = 1'b0;
        got_done = 1'b0;
        held     = '0;
        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == raise_at) begin
                chk("wait_stall_count", 32'(k), 32'(wr0));
                wr_count = 12'(wr1);
            end
            if (cyc == glitch_at) begin
                start      = 1'b1;
                start_addr = 11'd999;
            end else begin
                start = 1'b0;
            end
            if (ram_rden) begin
                chk("rd_addr", 32'(ram_address), 32'((s_addr + rd) % 2048));
                chk("rd_gate", 32'(rd < int'(wr_count)), 1);
                rd++;
            end
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(held));
            end
            hold = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    chk("sample", 32'(out_data), 32'(((s_addr + k) % 2048) + 100));
                    if (chk_gap && last_hs >= 0) chk("gap", 32'(cyc - last_hs), 3);
                    last_hs = cyc;
                    k++;
                end else begin
                    hold = 1'b1;
                    held = out_data;
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("sample_count", 32'(k), 32'(n));
                chk("read_count", 32'(rd), 32'(n));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_seen", 32'(got_done), 1);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after", 32'(busy), 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        start_addr  = '0;
        num_samples = '0;
        wr_count    = '0;
        out_ready   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_done", 32'(done), 0);
        chk("post_reset_rden", 32'(ram_rden), 0);

        // Basic drain, ready held high: 100..103 at 3-cycle spacing
        run_drain(0, 4, 4, -1, 0, 1'b0, 1'b1, -1);

        // Random backpressure plus a start pulse mid-drain that must be ignored
        run_drain(10, 6, 6, -1, 0, 1'b1, 1'b0, 4);

        // wr_count gating: two samples, stall, then three more
        run_drain(0, 5, 2, 20, 5, 1'b0, 1'b0, -1);

        // Address wrap 2046, 2047, 0, 1
        run_drain(2046, 4, 4, -1, 0, 1'b0, 1'b1, -1);

        // Zero-length drain: done one cycle after start, no reads
        start_addr  = 11'd7;
        num_samples = 12'd0;
        wr_count    = 12'd0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 1);
        chk("zero_rden", 32'(ram_rden), 0);
        @(posedge clk); #1;
        chk("zero_done_end", 32'(done), 0);
        chk("zero_idle", 32'(busy), 0);
        chk("zero_rden_end", 32'(ram_rden), 0);

        // Reset while presenting a sample
        start_addr  = 11'd5;
        num_samples = 12'd3;
        wr_count    = 12'd3;
        out_ready   = 1'b0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_data", 32'(out_data), 105);
        chk("pre_rst_addr", 32'(ram_address), 5);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_done", 32'(done), 0);
        chk("after_rst_rden", 32'(ram_rden), 0);
        chk("after_rst_busy", 32'(busy), 0);
        run_drain(5, 3, 3, -1, 0, 1'b0, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_readout.md
BRAM_READOUT -- requirements
Module: bram_readout

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the RAM address width.
REQ-002 SHALL have parameter DATA_W, default 12, meaning the sample width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: begin a drain; sampled in IDLE only.
REQ-006 SHALL have port start_addr, input, ADDR_W: first RAM address of the drain.
REQ-007 SHALL have port num_samples, input, ADDR_W+1: samples to drain, 0..2^ADDR_W.
REQ-008 SHALL have port wr_count, input, ADDR_W+1: samples the beamformer has written since start_addr.
REQ-009 SHALL have port ram_address, output, ADDR_W: read address to the output signal RAM.
REQ-010 SHALL have port ram_rden, output, 1: RAM read enable.
REQ-011 SHALL have port ram_q, input, DATA_W: RAM read data.
REQ-012 SHALL have port out_data, output, DATA_W: streamed sample.
REQ-013 SHALL have port out_valid, output, 1: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1: the downstream block accepts the sample.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse when a drain completes.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, ISSUE, CAPTURE, PRESENT and DONE.
REQ-018 SHALL, in IDLE with start=1, latch start_addr into addr, num_samples into target, clear rd_cnt, and go to DONE if num_samples=0, else WAIT.
REQ-019 SHALL, in WAIT, go to ISSUE when rd_cnt < wr_count, else remain in WAIT, so no unwritten address is ever read.
REQ-020 SHALL, in ISSUE, drive ram_address=addr and ram_rden=1 for exactly one cycle, then go to CAPTURE.
REQ-021 SHALL treat RAM read latency as one cycle: ram_q is valid in CAPTURE; the FSM registers it into out_data and goes to PRESENT.
REQ-022 SHALL hold out_valid=1 and out_data stable throughout PRESENT until out_ready=1.
REQ-023 SHALL, on handshake (out_valid & out_ready), increment rd_cnt and addr, then go to DONE if rd_cnt+1 = target, else WAIT.
REQ-024 SHALL increment addr modulo 2^ADDR_W, so 2047 wraps to 0 at the default width.
REQ-025 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-026 SHALL ignore start whenever the FSM is not in IDLE.
REQ-027 SHALL drive ram_rden=0 outside ISSUE; ram_address SHALL hold its last value.
REQ-028 SHALL be throughput-limited to at most one sample per 3 cycles (ISSUE, CAPTURE, PRESENT) when out_ready is held high.
REQ-029 SHALL accept a wr_count that rises during a drain; a wr_count decrease is outside the specified operating range.

Reset
REQ-030 SHALL, on rst=1 at any time (including mid-drain), immediately force state=IDLE, addr=0, rd_cnt=0, target=0, ram_address=0, ram_rden=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst deasserts, with no spurious done pulse or RAM read.

Structure
REQ-032 SHALL take the FSM state encoding, ADDR_W and DATA_W defaults from the shared beamformer package used by brambeamformer.
REQ-033 SHALL be a single flat module with no sub-modules; the RAM is external and is the out_signalram instance owned by the top level.

Verification
REQ-034 SHALL cover: start_addr=0, num_samples=4, wr_count=4, RAM[i]=i+100, ready=1 -> out_data 100,101,102,103 at 3-cycle spacing, then one done pulse.
REQ-035 SHALL cover: ready toggling 1/0 randomly -> out_data stable while valid&!ready, no sample dropped or duplicated.
REQ-036 SHALL cover: wr_count=2, num_samples=5, wr_count raised to 5 after 20 cycles -> two samples, FSM waits in WAIT with no ram_rden, then three more samples.
REQ-037 SHALL cover: start_addr=2046, num_samples=4 -> addresses 2046, 2047, 0, 1 are read.
REQ-038 SHALL cover: num_samples=0 -> done pulses one cycle after start, ram_rden never asserted.
REQ-039 SHALL cover: rst asserted in PRESENT during a drain -> all outputs 0 immediately, and a new start completes a full drain correctly.
